// File: rtl/decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered RV32I/RV64I instruction decode stage. It decodes
//             one instruction per cycle over valid/ready, holds results in a
//             2-entry skid buffer, supports flush, and counts delivered
//             illegal instructions with a saturating counter.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1,
   parameter int PC_W     = 32,
   parameter int CNT_W    = 16,
   localparam int SHW     = (XLEN == 64) ? 6 : 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       out_opc,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_func3,
   output logic [6:0]       out_func7,
   output logic [XLEN-1:0]  out_imm,
   output logic [SHW-1:0]   out_shamt,
   output logic [PC_W-1:0]  out_pc,
   output logic             out_illegal,
   output logic             out_is_muldiv,
   output logic [CNT_W-1:0] illegal_count
);

   // Major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // func7 values accepted on OP
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   // One decoded instruction as held in either buffer entry
   typedef struct packed {
      logic [6:0]      opc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [XLEN-1:0] imm;
      logic [SHW-1:0]  shamt;
      logic [PC_W-1:0] pc;
      logic            illegal;
      logic            muldiv;
   } dec_t;

   // Raw decode results (before illegal masking)
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [2:0]      w_func3;
   logic [6:0]      w_func7;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [SHW-1:0]  w_shamt;
   logic            w_illegal;
   logic            w_muldiv;
   dec_t            w_dec;
   logic            w_accept;

   // Skid buffer state: M drives the outputs, S catches the overflow entry
   logic             m_valid_q, m_valid_d;
   logic             s_valid_q, s_valid_d;
   logic             in_ready_q, in_ready_d;
   dec_t             m_q, m_d;
   dec_t             s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Field extraction and legality check per major opcode
   always_comb begin
      w_rd      = '0;
      w_rs1     = '0;
      w_rs2     = '0;
      w_func3   = '0;
      w_func7   = '0;
      w_imm32   = '0;
      w_shamt   = '0;
      w_illegal = 1'b0;
      w_muldiv  = 1'b0;
      case (in_inst[6:0])
         OPC_OP: begin
            w_rd    = in_inst[11:7];
            w_rs1   = in_inst[19:15];
            w_rs2   = in_inst[24:20];
            w_func3 = in_inst[14:12];
            w_func7 = in_inst[31:25];
            if (in_inst[31:25] == F7_BASE) begin
               w_illegal = 1'b0;
            end else if (in_inst[31:25] == F7_ALT) begin
               // Only sub and sra exist in the alternate encoding
               w_illegal = (in_inst[14:12] != 3'b000) && (in_inst[14:12] != 3'b101);
            end else if ((in_inst[31:25] == F7_MULDIV) && (ENABLE_M != 0)) begin
               w_muldiv = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            w_rd    = in_inst[11:7];
            w_rs1   = in_inst[19:15];
            w_func3 = in_inst[14:12];
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            if ((in_inst[14:12] == 3'b001) || (in_inst[14:12] == 3'b101)) begin
               w_shamt = in_inst[20 +: SHW];
               // A 6-bit shift amount is meaningless on a 32-bit datapath
               if ((XLEN == 32) && in_inst[25]) begin
                  w_illegal = 1'b1;
               end
            end
         end
         OPC_JALR, OPC_LOAD: begin
            w_rd    = in_inst[11:7];
            w_rs1   = in_inst[19:15];
            w_func3 = in_inst[14:12];
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_STORE: begin
            w_rs1   = in_inst[19:15];
            w_rs2   = in_inst[24:20];
            w_func3 = in_inst[14:12];
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         OPC_BRANCH: begin
            w_rs1   = in_inst[19:15];
            w_rs2   = in_inst[24:20];
            w_func3 = in_inst[14:12];
            w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            w_rd    = in_inst[11:7];
            w_imm32 = {in_inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            w_rd    = in_inst[11:7];
            w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};
         end
         OPC_SYSTEM: begin
            w_illegal = 1'b0;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
      // Compressed / non-32-bit encodings are not supported
      if (in_inst[1:0] != 2'b11) begin
         w_illegal = 1'b1;
      end
   end

   // Sign-extend the 32-bit immediate up to the datapath width
   generate
      if (XLEN > 32) begin : g_imm_wide
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_imm_narrow
         assign w_imm = w_imm32[XLEN-1:0];
      end
   endgenerate

   // Assemble the entry to capture; illegal ops keep only opcode and PC
   always_comb begin
      w_dec         = '0;
      w_dec.opc     = in_inst[6:0];
      w_dec.pc      = in_pc;
      w_dec.illegal = w_illegal;
      if (!w_illegal) begin
         w_dec.rd     = w_rd;
         w_dec.rs1    = w_rs1;
         w_dec.rs2    = w_rs2;
         w_dec.func3  = w_func3;
         w_dec.func7  = w_func7;
         w_dec.imm    = w_imm;
         w_dec.shamt  = w_shamt;
         w_dec.muldiv = w_muldiv;
      end
   end

   assign w_accept = in_valid & in_ready_q;

   // Skid buffer next state: M refills from S before new input, FIFO order
   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_d       = m_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      if (flush) begin
         // Flush wins over every handshake, including the output one
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else begin
         if (m_valid_q && out_ready && m_q.illegal && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (!m_valid_q || out_ready) begin
            if (s_valid_q) begin
               m_d       = s_q;
               m_valid_d = 1'b1;
               s_valid_d = w_accept;
               if (w_accept) begin
                  s_d = w_dec;
               end
            end else begin
               m_valid_d = w_accept;
               if (w_accept) begin
                  m_d = w_dec;
               end
            end
         end else if (w_accept) begin
            s_d       = w_dec;
            s_valid_d = 1'b1;
         end
      end
      in_ready_d = !s_valid_d;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b0;
         m_q        <= '0;
         s_q        <= '0;
         cnt_q      <= '0;
      end else begin
         m_valid_q  <= m_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= in_ready_d;
         m_q        <= m_d;
         s_q        <= s_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = m_valid_q;
   assign out_opc       = m_q.opc;
   assign out_rd        = m_q.rd;
   assign out_rs1       = m_q.rs1;
   assign out_rs2       = m_q.rs2;
   assign out_func3     = m_q.func3;
   assign out_func7     = m_q.func7;
   assign out_imm       = m_q.imm;
   assign out_shamt     = m_q.shamt;
   assign out_pc        = m_q.pc;
   assign out_illegal   = m_q.illegal;
   assign out_is_muldiv = m_q.muldiv;
   assign illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. Two instances share one
//             stimulus stream: A (XLEN=64, M enabled, 2-bit counter) and
//             B (XLEN=32, M disabled, 16-bit counter).
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   logic        a_in_ready, a_out_valid, a_out_illegal, a_out_is_muldiv;
   logic [6:0]  a_out_opc, a_out_func7;
   logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
   logic [2:0]  a_out_func3;
   logic [63:0] a_out_imm;
   logic [5:0]  a_out_shamt;
   logic [31:0] a_out_pc;
   logic [1:0]  a_illegal_count;

   logic        b_in_ready, b_out_valid, b_out_illegal, b_out_is_muldiv;
   logic [6:0]  b_out_opc, b_out_func7;
   logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
   logic [2:0]  b_out_func3;
   logic [31:0] b_out_imm;
   logic [4:0]  b_out_shamt;
   logic [31:0] b_out_pc;
   logic [15:0] b_illegal_count;

   decode_stage #(.XLEN(64), .ENABLE_M(1), .PC_W(32), .CNT_W(2)) u_a (
      .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_opc(a_out_opc),
      .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
      .out_func3(a_out_func3), .out_func7(a_out_func7), .out_imm(a_out_imm),
      .out_shamt(a_out_shamt), .out_pc(a_out_pc), .out_illegal(a_out_illegal),
      .out_is_muldiv(a_out_is_muldiv), .illegal_count(a_illegal_count)
   );

   decode_stage #(.XLEN(32), .ENABLE_M(0), .PC_W(32), .CNT_W(16)) u_b (
      .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_opc(b_out_opc),
      .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
      .out_func3(b_out_func3), .out_func7(b_out_func7), .out_imm(b_out_imm),
      .out_shamt(b_out_shamt), .out_pc(b_out_pc), .out_illegal(b_out_illegal),
      .out_is_muldiv(b_out_is_muldiv), .illegal_count(b_illegal_count)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected decode, always with a 64-bit immediate (XLEN=32 uses the low half)
   typedef struct packed {
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic [5:0]  shamt;
      logic        ill;
      logic        md;
   } exp_t;

   function automatic exp_t model_dec(input logic [31:0] w, input int xlen, input bit en_m);
      exp_t   e;
      longint s;
      bit     bad;
      e   = '0;
      s   = $signed(w);
      bad = (w[1:0] != 2'b11);
      case (w[6:0])
         7'h33: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.f3 = w[14:12]; e.f7 = w[31:25];
            if (e.f7 == 7'h01) begin
               if (en_m) e.md = 1'b1; else bad = 1'b1;
            end else if (e.f7 == 7'h20) begin
               if (!(e.f3 == 3'd0 || e.f3 == 3'd5)) bad = 1'b1;
            end else if (e.f7 != 7'h00) begin
               bad = 1'b1;
            end
         end
         7'h13: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12];
            e.imm = s >>> 20;
            if (e.f3 == 3'd1 || e.f3 == 3'd5) begin
               if (xlen == 32) begin
                  e.shamt = {1'b0, w[24:20]};
                  if (w[25]) bad = 1'b1;
               end else begin
                  e.shamt = w[25:20];
               end
            end
         end
         7'h67, 7'h03: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12];
            e.imm = s >>> 20;
         end
         7'h23: begin
            e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
            e.imm = ((s >>> 25) * 32) + longint'(w[11:7]);
         end
         7'h63: begin
            e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
            e.imm = ((s >>> 31) * 4096) + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         end
         7'h37, 7'h17: begin
            e.rd = w[11:7];
            e.imm = (s >>> 12) * 4096;
         end
         7'h6F: begin
            e.rd = w[11:7];
            e.imm = ((s >>> 31) * 1048576) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
         end
         7'h73: begin
            e.rd = 5'd0;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         e = '0;
         e.ill = 1'b1;
      end
      e.opc = w[6:0];
      return e;
   endfunction

   // Transaction model: the stage is a 2-deep FIFO of accepted instructions
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } txn_t;

   txn_t        q[$];
   bit          rdy_m = 1'b0;
   bit          in_rst_m = 1'b1;
   int unsigned cnt_a = 0;
   int unsigned cnt_b = 0;

   // Compare against the model, then advance the model for the coming edge
   always @(negedge clk) begin
      exp_t ea, eb;
      txn_t t;
      check("a_out_valid", a_out_valid, q.size() > 0);
      check("b_out_valid", b_out_valid, q.size() > 0);
      check("a_in_ready", a_in_ready, rdy_m);
      check("b_in_ready", b_in_ready, rdy_m);
      check("a_illegal_count", a_illegal_count, cnt_a);
      check("b_illegal_count", b_illegal_count, cnt_b);
      if (in_rst_m) begin
         check("a_fields_in_reset", {a_out_opc, a_out_rd, a_out_rs1, a_out_rs2, a_out_func3,
               a_out_func7, a_out_imm, a_out_shamt, a_out_pc, a_out_illegal, a_out_is_muldiv}, 0);
      end
      if (q.size() > 0) begin
         ea = model_dec(q[0].inst, 64, 1'b1);
         eb = model_dec(q[0].inst, 32, 1'b0);
         check("a_fields", {a_out_opc, a_out_rd, a_out_rs1, a_out_rs2, a_out_func3, a_out_func7,
               a_out_imm, a_out_shamt, a_out_illegal, a_out_is_muldiv}, ea);
         check("b_fields", {b_out_opc, b_out_rd, b_out_rs1, b_out_rs2, b_out_func3, b_out_func7,
               {{32{b_out_imm[31]}}, b_out_imm}, {1'b0, b_out_shamt}, b_out_illegal,
               b_out_is_muldiv}, eb);
         check("a_out_pc", a_out_pc, q[0].pc);
         check("b_out_pc", b_out_pc, q[0].pc);
      end
      if (!rst_n) begin
         q.delete();
         rdy_m    = 1'b0;
         in_rst_m = 1'b1;
         cnt_a    = 0;
         cnt_b    = 0;
      end else begin
         in_rst_m = 1'b0;
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && out_ready) begin
               t = q.pop_front();
               ea = model_dec(t.inst, 64, 1'b1);
               eb = model_dec(t.inst, 32, 1'b0);
               if (ea.ill && cnt_a < 3) cnt_a++;
               if (eb.ill && cnt_b < 65535) cnt_b++;
            end
            if (in_valid && rdy_m) begin
               q.push_back('{inst: in_inst, pc: in_pc});
            end
         end
         rdy_m = (q.size() < 2);
      end
   end

   // Present one instruction until accepted (bounded)
   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      int  n;
      bit  took;
      n    = 0;
      took = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      while (!took) begin
         took = a_in_ready;
         @(posedge clk); #2;
         if (!took) begin
            n++;
            if (n > 50) begin
               vectors++;
               miscompares++;
               $display("FAIL send_timeout: got no accept expected accept within 50 cycles (pc %0h)", pc);
               break;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   bit done = 1'b0;

   initial begin
      // Reset held with an instruction presented
      rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h0; out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #2;
      end
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_in_ready", a_in_ready, 1'b0);
      check("rst_count", a_illegal_count, 2'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      idle(1);
      check("rst_release_ready", a_in_ready, 1'b1);

      // mul: legal with M on A, illegal on B
      send(32'h02000033, 32'h100);
      check("mul_a_muldiv", a_out_is_muldiv, 1'b1);
      check("mul_a_illegal", a_out_illegal, 1'b0);
      check("mul_b_illegal", b_out_illegal, 1'b1);
      check("mul_b_muldiv", b_out_is_muldiv, 1'b0);
      idle(1);
      check("mul_a_count", a_illegal_count, 2'd0);
      check("mul_b_count", b_illegal_count, 16'd1);

      // Immediate forms, streamed back to back
      send(32'hFFF10093, 32'h104);      // addi x1,x2,-1
      check("addi_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_rd_rs1", {a_out_rd, a_out_rs1}, {5'd1, 5'd2});
      send(32'hFE532E23, 32'h108);      // sw x5,-4(x6)
      check("sw_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("sw_rs", {a_out_rs1, a_out_rs2, a_out_rd}, {5'd6, 5'd5, 5'd0});
      send(32'hFE208CE3, 32'h10C);      // beq x1,x2,-8
      check("beq_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      send(32'h001000EF, 32'h110);      // jal x1,+2048
      check("jal_imm", a_out_imm, 64'h800);
      send(32'h02809093, 32'h114);      // slli x1,x1,40
      check("slli_shamt", a_out_shamt, 6'd40);
      check("slli_b_illegal", b_out_illegal, 1'b1);
      idle(1);

      // Back-pressure: two absorbed, then in_ready drops
      out_ready = 1'b0;
      send(32'h00100093, 32'h200);
      send(32'h00200113, 32'h204);
      check("bp_in_ready_low", a_in_ready, 1'b0);
      idle(1);
      check("bp_hold_pc", a_out_pc, 32'h200);
      out_ready = 1'b1;
      send(32'h00300193, 32'h208);
      send(32'h00400213, 32'h20C);
      idle(3);

      // Flush with two held and a third presented
      out_ready = 1'b0;
      send(32'h00500293, 32'h300);
      send(32'h00600313, 32'h304);
      in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h308; flush = 1'b1;
      idle(1);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", a_out_valid, 1'b0);
      out_ready = 1'b1;
      idle(3);

      // All-zero word is illegal
      send(32'h00000000, 32'h400);
      check("zero_illegal", a_out_illegal, 1'b1);
      check("zero_fields", {a_out_rd, a_out_imm, a_out_pc}, {5'd0, 64'd0, 32'h400});
      idle(1);
      check("zero_a_count", a_illegal_count, 2'd1);

      // Reset mid-operation drops held entries
      out_ready = 1'b0;
      send(32'h00800413, 32'h500);
      send(32'h00900493, 32'h504);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("midrst_out_valid", a_out_valid, 1'b0);
      check("midrst_count", a_illegal_count, 2'd0);
      idle(1);
      check("midrst_ready", a_in_ready, 1'b1);

      // Saturation: five illegal deliveries on a 2-bit counter
      out_ready = 1'b1;
      send(32'h00000000, 32'h600);
      send(32'h0000007F, 32'h604);
      send(32'h40001033, 32'h608);
      send(32'h04000033, 32'h60C);
      send(32'h00000001, 32'h610);
      idle(1);
      check("sat_a_count", a_illegal_count, 2'd3);
      check("sat_b_count", b_illegal_count, 16'd5);

      // Mixed opcodes under an irregular out_ready pattern
      done = 1'b0;
      fork
         begin
            send(32'h12345037, 32'h700);  // lui
            send(32'hFFFFF097, 32'h704);  // auipc
            send(32'h00412083, 32'h708);  // lw x1,4(x2)
            send(32'h000080E7, 32'h70C);  // jalr
            send(32'h00000073, 32'h710);  // ecall
            send(32'h40208033, 32'h714);  // sub
            send(32'h4020D033, 32'h718);  // sra
            send(32'h4030D093, 32'h71C);  // srai x1,x1,3
            send(32'h0220C0B3, 32'h720);  // div
            done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!done) begin
               out_ready = ((k % 3) != 2);
               k++;
               @(posedge clk); #2;
            end
         end
      join
      out_ready = 1'b1;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction decode stage for the RV32I/RV64I core. It sits between fetch and execute and accepts one instruction word plus PC per cycle over a valid/ready handshake. It produces the decoded fields (opcode, register indices, func3/func7, sign-extended immediate, shift amount) one cycle later. Unlike the earlier purely combinational decoder, it adds:
- a 2-entry skid buffer for full-throughput back-pressure;
- a flush input;
- XLEN generalisation and optional M-extension decode;
- illegal-instruction detection with a saturating error counter.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64. Sets the immediate width and the shift-amount width.
- ENABLE_M, 1, 1 = accept func7 7'b0000001 on OP (mul/div) and set out_is_muldiv.
- PC_W, 32, width of the PC carried alongside the instruction.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clock, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low; the block is in reset when sampled low.
- in_valid, in, 1, fetch presents an instruction.
- in_ready, out, 1, stage can accept; driven from a register only, with no combinational path from out_ready.
- in_inst, in, 32, instruction word.
- in_pc, in, PC_W, PC of in_inst.
- flush, in, 1, discard all held and incoming instructions.
- out_valid, out, 1, decoded instruction available.
- out_ready, in, 1, execute accepts.
- out_opc, out, 7, inst[6:0].
- out_rd, out, 5, destination register index.
- out_rs1, out, 5, source register 1 index.
- out_rs2, out, 5, source register 2 index.
- out_func3, out, 3, function field.
- out_func7, out, 7, function field.
- out_imm, out, XLEN, sign-extended immediate.
- out_shamt, out, SHW, shift amount; SHW = 5 if XLEN=32, 6 if XLEN=64.
- out_pc, out, PC_W, PC of the output instruction.
- out_illegal, out, 1, output instruction is illegal.
- out_is_muldiv, out, 1, output is an M-extension op.
- illegal_count, out, CNT_W, saturating count of illegal instructions delivered on the output.

## Operation
- Field extraction per opcode:
  - OP 0110011: rd, rs1, rs2, func3, func7; imm=0.
  - OP-IMM 0010011, JALR 1100111, LOAD 0000011: rd, rs1, func3, imm = sext(inst[31:20]).
  - STORE 0100011: rs1, rs2, func3, imm = sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011: rs1, rs2, func3, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - LUI 0110111 and AUIPC 0010111: rd, imm = sext({inst[31:12], 12'b0}).
  - JAL 1101111: rd, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - SYSTEM 1110011: all fields 0.
- Sign extension is always from inst[31] up to XLEN bits.
- Fields not used by an opcode are driven 0.
- out_shamt: on OP-IMM with func3 001 or 101 it equals inst[20+SHW-1:20]; otherwise 0.
- Illegal conditions:
  - inst[1:0] != 2'b11;
  - opcode not in the list above;
  - on OP: func7 not in {0000000, 0100000, and 0000001 if ENABLE_M};
  - on OP: func7 0100000 with func3 not in {000, 101};
  - when XLEN=32: OP-IMM func3 001/101 with inst[25]=1.
- Illegal instructions still flow down the pipeline with out_illegal=1, all other fields 0 except out_opc and out_pc.
- out_is_muldiv=1 only when ENABLE_M=1 and the op is OP with func7 0000001.
- Skid buffer: main register M and skid register S, each with a valid bit.
  - in_ready = reset & ~S.valid, registered.
  - Accepting an input (in_valid & in_ready) while M is free or draining (~M.valid | out_ready) loads M, from S first if S is valid.
  - Otherwise the input is written to S.
  - Ordering is strictly FIFO.
- Decode is performed before capture; registers hold decoded fields, not raw instructions.
- flush: M.valid and S.valid clear on the next edge. An input accepted in the same cycle is discarded. illegal_count is unaffected.
- illegal_count increments on each output handshake (out_valid & out_ready & out_illegal) and saturates at all-ones.

## Timing
- Reset, while reset is low at an edge: out_valid=0, in_ready=0, and all out_* fields=0. In the cycle after reset is released, in_ready=1. illegal_count=0.
- Reset mid-operation drops held instructions without delivering them.
- Latency: the input handshake at edge n gives out_valid=1 after edge n, visible in cycle n+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Back-pressure: with out_ready=0 the stage absorbs at most 2 instructions. in_ready falls the cycle after S fills.
- Output fields are stable while out_valid=1 and out_ready=0.
- On release of out_ready after a stall, S drains to M in 1 cycle. in_ready rises the following cycle.
- flush has priority over every handshake in the same cycle.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, illegal_count=0; in_ready=1 on the first cycle after release.
- Decode, XLEN=64: stream `addi x1,x2,-1` (0xFFF10093), `sw x5,-4(x6)` (0xFE532E23), `beq` with imm=-8, `jal` with imm=+2048 -> out_imm = 0xFFFFFFFFFFFFFFFF, 0x...FFFC, 0x...FFF8, 0x800 respectively. Also `slli x1,x1,40` -> out_shamt=40.
- Back-pressure: send 4 back-to-back instructions with out_ready=0 for 3 cycles -> in_ready=0 after the 2nd is accepted. All 4 emerge in order once out_ready=1, with no duplicates or drops.
- Illegal: send 0x02000033 (mul) with ENABLE_M=0 -> out_illegal=1, illegal_count=1. With ENABLE_M=1 -> out_is_muldiv=1, illegal_count=0. Send 0x00000000 -> illegal.
- Flush: 2 instructions held and a 3rd presented, with flush=1 -> out_valid=0 next cycle and none of the three is ever delivered.
- Counter saturation: CNT_W=2, deliver 5 illegal instructions -> illegal_count reads 3.
